// File: rtl/mioc_od_line_rx.sv
// mioc open-drain line receiver.
// Synchronises and deglitches the wired-AND line, measures each low pulse,
// decodes short/long/very-long lows into 1/0/frame-reset, assembles bytes
// LSB-first and hands them to a consumer over a valid/ready interface.
module mioc_od_line_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8,
    parameter int SHORT_MAX   = 15,
    parameter int LONG_MAX    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    input  logic       rx_ready,
    input  logic       ovf_clr,
    output logic       line_q,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ovf,
    output logic       frame_rst
);

    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_MAX);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [FW-1:0]          filt_cnt;

    state_t                 state;
    logic [CNT_W-1:0]       width;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;

    // Combinational decode of the pulse that ends in this cycle
    logic                   cls_valid;
    logic                   is_frame;
    logic                   bit_val;
    logic                   byte_done;
    logic [7:0]             next_shreg;
    logic                   load_ok;

    assign synced = sync[SYNC_STAGES-1];

    // Metastability synchroniser for the asynchronous line; idle level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
        end
    end

    // Deglitch: line_q only follows the synced level after FILT_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q   <= 1'b1;
            filt_cnt <= '0;
        end else if (synced != line_q) begin
            if (filt_cnt == FILT_LAST) begin
                line_q   <= synced;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Classify the finishing pulse and build the next shift-register value.
    // A saturated counter is always treated as a frame reset.
    always_comb begin
        cls_valid  = 1'b0;
        is_frame   = 1'b0;
        bit_val    = 1'b0;
        byte_done  = 1'b0;
        next_shreg = shreg;
        load_ok    = (!rx_valid) || rx_ready;
        if ((state == ST_LOW) && line_q) begin
            cls_valid = 1'b1;
            if ((width != CNT_MAX) && (width <= SHORT_LIM)) begin
                bit_val = 1'b1;
            end else if ((width != CNT_MAX) && (width <= LONG_LIM)) begin
                bit_val = 1'b0;
            end else begin
                is_frame = 1'b1;
            end
            if (!is_frame) begin
                next_shreg[bit_cnt] = bit_val;
                byte_done = (bit_cnt == 3'd7);
            end else begin
                byte_done = 1'b0;
            end
        end else begin
            cls_valid = 1'b0;
        end
    end

    // Pulse-width FSM, byte assembly and the registered consumer interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            width     <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_rst <= 1'b0;
        end else begin
            frame_rst <= cls_valid && is_frame;

            case (state)
                ST_IDLE: begin
                    if (!line_q) begin
                        state <= ST_LOW;
                        width <= CNT_ONE;
                    end else begin
                        width <= '0;
                    end
                end
                ST_LOW: begin
                    if (!line_q) begin
                        if (width != CNT_MAX) begin
                            width <= width + CNT_ONE;
                        end
                    end else begin
                        state <= ST_IDLE;
                        width <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    width <= '0;
                end
            endcase

            // Partial-byte state: a frame reset discards it, a bit extends it
            if (cls_valid) begin
                if (is_frame || byte_done) begin
                    bit_cnt <= 3'd0;
                    shreg   <= 8'h00;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= next_shreg;
                end
            end

            // Output register: a new byte may replace one being accepted now
            if (byte_done && load_ok) begin
                rx_data  <= next_shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // Overflow is sticky; a simultaneous new overflow beats the clear
            if (byte_done && !load_ok) begin
                rx_ovf <= 1'b1;
            end else if (ovf_clr) begin
                rx_ovf <= 1'b0;
            end
        end
    end

endmodule
